// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle Moore control FSM for the MIPS datapath.
// Outputs decode the registered state (plus op/funct); all are held at 0 during reset.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [1:0] RegDst,
    output logic       ALUSrcB,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSrc,
    output logic [1:0] EOp,
    output logic [1:0] ALUOp,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IMMEX  = 4'd10,
        IMMWB  = 4'd11
    } state_t;
    state_t st;
    logic rtype, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic pc_wr, ir_wr, reg_wr, mem_wr, alu_src_b;
    logic [1:0] reg_dst, mem_to_reg, pc_src, e_op, alu_op;
    assign rtype   = op == 6'b000000;
    assign is_addu = rtype && funct == 6'b100001;
    assign is_subu = rtype && funct == 6'b100011;
    assign is_jr   = rtype && funct == 6'b001000;
    assign is_ori  = op == 6'b001101;
    assign is_lui  = op == 6'b001111;
    assign is_lw   = op == 6'b100011;
    assign is_sw   = op == 6'b101011;
    assign is_beq  = op == 6'b000100;
    assign is_j    = op == 6'b000010;
    assign is_jal  = op == 6'b000011;
    always_ff @(posedge clk) begin
        if (reset) st <= FETCH;
        else case (st)
            FETCH:   st <= DECODE;
            DECODE:  st <= (is_lw || is_sw)          ? MEMADR :
                           (is_addu || is_subu)      ? EXEC   :
                           (is_ori || is_lui)        ? IMMEX  :
                           is_beq                    ? BRANCH :
                           (is_j || is_jal || is_jr) ? JUMP   : FETCH;
            MEMADR:  st <= is_lw ? MEMRD : MEMWR;
            MEMRD:   st <= MEMWB;
            EXEC:    st <= ALUWB;
            IMMEX:   st <= IMMWB;
            default: st <= FETCH;
        endcase
    end
    always_comb begin
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        reg_dst    = 2'b00;
        alu_src_b  = 1'b0;
        mem_to_reg = 2'b00;
        pc_src     = 2'b00;
        e_op       = 2'b00;
        alu_op     = 2'b00;
        case (st)
            FETCH:  begin pc_wr = 1'b1; ir_wr = 1'b1; end
            MEMADR: alu_src_b = 1'b1;
            MEMWB:  begin reg_wr = 1'b1; mem_to_reg = 2'b01; end
            MEMWR:  mem_wr = 1'b1;
            EXEC:   alu_op = 2'b11;
            ALUWB:  begin reg_wr = 1'b1; reg_dst = 2'b01; alu_op = 2'b11; end
            // lui adds the shifted immediate to $0, so it keeps the add opcode
            IMMEX, IMMWB: begin
                alu_src_b = st == IMMEX;
                reg_wr    = st == IMMWB;
                e_op      = is_lui ? 2'b10 : 2'b01;
                alu_op    = is_lui ? 2'b00 : 2'b10;
            end
            BRANCH: begin pc_wr = zero; pc_src = 2'b01; e_op = 2'b11; alu_op = 2'b01; end
            JUMP: begin
                pc_wr      = 1'b1;
                pc_src     = is_jr ? 2'b11 : 2'b10;
                reg_wr     = is_jal;
                reg_dst    = is_jal ? 2'b10 : 2'b00;
                mem_to_reg = is_jal ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end
    assign {PCWr, IRWr, RegWr, MemWr, RegDst, ALUSrcB, MemtoReg, PCSrc, EOp, ALUOp, state} =
        reset ? 19'd0 : {pc_wr, ir_wr, reg_wr, mem_wr, reg_dst, alu_src_b, mem_to_reg, pc_src, e_op, alu_op, st};
endmodule
